// File: rtl/lfsr_pkg.sv
// lfsr_pkg -- shared definitions for the LFSR-addressed read sequencer.
//   state_t    : sequencer FSM states
//   LFSR_TAPS  : tap mask for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
//   lfsr_next  : one Fibonacci shift step of the 8-bit LFSR
package lfsr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    TRIG,
    DONE
  } state_t;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Feedback is the XOR of the tapped bits, shifted in at the LSB.
  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr8.sv
// lfsr8 -- 8-bit Fibonacci LFSR with synchronous load and step.
// Ports:
//   Clk   : clock (rising edge)
//   Reset : synchronous active-high reset, loads SEED_FIX
//   Load  : load Seed (has priority over Step)
//   Step  : advance one LFSR step
//   Seed  : load value (caller guarantees non-zero)
//   Q     : current LFSR value
module lfsr8
  import lfsr_pkg::*;
#(
  parameter logic [7:0] SEED_FIX = 8'h01
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Load,
  input  logic       Step,
  input  logic [7:0] Seed,
  output logic [7:0] Q
);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Q <= SEED_FIX;
    end else if (Load) begin
      Q <= Seed;
    end else if (Step) begin
      Q <= lfsr_next(Q);
    end
  end

endmodule

// File: rtl/lfsr_read_seq.sv
// lfsr_read_seq -- sweeps a memory at LFSR-generated addresses, registers each
// read word and pulses Trigger so a downstream latch can capture it.
// Optional feature: define LFSR_MATCH_EN to add key matching (Key, Match,
// Match_Addr); a matching read ends the sweep after its TRIG cycle.
// Ports:
//   Clk, Reset     : clock, synchronous active-high reset
//   Start          : begin a sweep (accepted only in IDLE)
//   Seed           : LFSR start value (0 replaced by SEED_FIX), sampled on Start
//   Num_Reads      : reads in the sweep, sampled on Start
//   Mem_En/Mem_Addr: one-cycle read strobe and address
//   Mem_Data       : read data, valid RD_LAT cycles after Mem_En
//   Data_Out       : registered read word
//   Trigger        : one-cycle capture pulse (Data_Out stable through it)
//   Busy           : high in ISSUE/WAIT/TRIG
//   Done           : one-cycle end-of-sweep pulse
//   Key/Match/Match_Addr : match feature (LFSR_MATCH_EN only)
module lfsr_read_seq
  import lfsr_pkg::*;
#(
  parameter int unsigned RD_LAT   = 1,
  parameter logic [7:0]  SEED_FIX = 8'h01
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [7:0] Seed,
  input  logic [7:0] Num_Reads,
`ifdef LFSR_MATCH_EN
  input  logic [7:0] Key,
  output logic       Match,
  output logic [7:0] Match_Addr,
`endif
  output logic       Mem_En,
  output logic [7:0] Mem_Addr,
  input  logic [7:0] Mem_Data,
  output logic [7:0] Data_Out,
  output logic       Trigger,
  output logic       Busy,
  output logic       Done
);

  localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

  state_t     state, state_nxt;
  logic [7:0] count;
  logic [1:0] wait_cnt;
  logic [7:0] addr_hold;
  logic [7:0] lfsr_q;
  logic [7:0] seed_eff;
  logic       accept;
  logic       wait_last;
  logic       stop_early;

  assign accept    = (state == IDLE) && Start;
  assign wait_last = (state == WAIT) && (wait_cnt == WAIT_LAST);
  assign seed_eff  = (Seed == 8'h00) ? SEED_FIX : Seed;

  lfsr8 #(
    .SEED_FIX(SEED_FIX)
  ) u_lfsr (
    .Clk  (Clk),
    .Reset(Reset),
    .Load (accept),
    .Step (state == TRIG),
    .Seed (seed_eff),
    .Q    (lfsr_q)
  );

`ifdef LFSR_MATCH_EN
  logic [7:0] key_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      key_q      <= '0;
      Match      <= 1'b0;
      Match_Addr <= '0;
    end else if (accept) begin
      key_q      <= Key;
      Match      <= 1'b0;
      Match_Addr <= '0;
    end else if (wait_last && (Mem_Data == key_q)) begin
      Match      <= 1'b1;
      Match_Addr <= lfsr_q;
    end
  end

  // Match is cleared on every accepted Start, so it only reflects this sweep.
  assign stop_early = Match;
`else
  assign stop_early = 1'b0;
`endif

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (Start) begin
          state_nxt = (Num_Reads != 8'h00) ? ISSUE : DONE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (wait_last) begin
          state_nxt = TRIG;
        end
      end
      // count still holds the pre-decrement value here
      TRIG:    state_nxt = ((count == 8'd1) || stop_early) ? DONE : ISSUE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    Mem_En   = (state == ISSUE);
    Trigger  = (state == TRIG);
    Busy     = (state == ISSUE) || (state == WAIT) || (state == TRIG);
    Done     = (state == DONE);
    // LFSR is only stepped at the end of TRIG, so during ISSUE it equals the
    // address; afterwards the held copy keeps Mem_Addr steady.
    Mem_Addr = Mem_En ? lfsr_q : addr_hold;
  end

  // Datapath registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count     <= '0;
      wait_cnt  <= '0;
      addr_hold <= '0;
      Data_Out  <= '0;
    end else begin
      if (accept) begin
        count <= Num_Reads;
      end
      if (state == ISSUE) begin
        addr_hold <= lfsr_q;
        wait_cnt  <= '0;
      end
      if (state == WAIT) begin
        wait_cnt <= wait_cnt + 2'd1;
      end
      if (wait_last) begin
        Data_Out <= Mem_Data;
      end
      if (state == TRIG) begin
        count <= count - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_read_seq.sv
// tb_lfsr_read_seq -- directed, table-driven bench for lfsr_read_seq.
// Two DUT instances (RD_LAT=1 and RD_LAT=3), each with a memory model that
// returns ~Addr after the instance's read latency.
module tb_lfsr_read_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start1, start3;
  logic [7:0] seed, num, key;

  logic       en1, en3, trig1, trig3, busy1, busy3, done1, done3;
  logic [7:0] addr1, addr3, dout1, dout3;
  logic [7:0] md1 = '0, md3 = '0, p3a = '0, p3b = '0;
`ifdef LFSR_MATCH_EN
  logic       match1, match3;
  logic [7:0] maddr1, maddr3;
`endif

  lfsr_read_seq #(.RD_LAT(1), .SEED_FIX(8'h01)) u_dut1 (
    .Clk(clk), .Reset(rst), .Start(start1), .Seed(seed), .Num_Reads(num),
`ifdef LFSR_MATCH_EN
    .Key(key), .Match(match1), .Match_Addr(maddr1),
`endif
    .Mem_En(en1), .Mem_Addr(addr1), .Mem_Data(md1), .Data_Out(dout1),
    .Trigger(trig1), .Busy(busy1), .Done(done1)
  );

  lfsr_read_seq #(.RD_LAT(3), .SEED_FIX(8'h01)) u_dut3 (
    .Clk(clk), .Reset(rst), .Start(start3), .Seed(seed), .Num_Reads(num),
`ifdef LFSR_MATCH_EN
    .Key(key), .Match(match3), .Match_Addr(maddr3),
`endif
    .Mem_En(en3), .Mem_Addr(addr3), .Mem_Data(md3), .Data_Out(dout3),
    .Trigger(trig3), .Busy(busy3), .Done(done3)
  );

  // Memory models: data = ~Addr, delivered RD_LAT cycles after the strobe.
  always @(posedge clk) begin
    md1 <= ~addr1;
    p3a <= ~addr3;
    p3b <= p3a;
    md3 <= p3b;
  end

  // Selected-instance view used by the sweep task
  bit         sel = 1'b0;
  logic       en_s, trig_s, busy_s, done_s;
  logic [7:0] addr_s, dout_s;
  always_comb begin
    en_s   = sel ? en3   : en1;
    trig_s = sel ? trig3 : trig1;
    busy_s = sel ? busy3 : busy1;
    done_s = sel ? done3 : done1;
    addr_s = sel ? addr3 : addr1;
    dout_s = sel ? dout3 : dout1;
  end

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  logic [7:0]  addr_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // Start a sweep, then follow it cycle by cycle until Done (bounded).
  task automatic run_sweep(input bit lat3, input logic [7:0] sd, input logic [7:0] nr,
                           input bit hold, input string tag,
                           output int unsigned n_trig, output int unsigned done_cyc);
    int unsigned lat;
    bit          trig_prev;
    logic [7:0]  held, last_a, exp_d;
    int unsigned n_en;
    lat = lat3 ? 3 : 1;
    trig_prev = 1'b0;
    held = '0;
    last_a = '0;
    n_en = 0;
    n_trig = 0;
    done_cyc = 0;
    sel = lat3;
    addr_q.delete();
    @(negedge clk);
    seed = sd;
    num  = nr;
    if (lat3) start3 = 1'b1; else start1 = 1'b1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        if (!hold) begin
          start1 = 1'b0;
          start3 = 1'b0;
        end
        // Changing these after Start must have no effect on the sweep
        seed = 8'hAA;
        num  = 8'hFF;
      end
      if (trig_prev) chk({tag, "_dout_hold"}, dout_s, held);
      trig_prev = 1'b0;
      if (en_s) begin
        addr_q.push_back(addr_s);
        last_a = addr_s;
        n_en++;
      end
      if (trig_s) begin
        n_trig++;
        exp_d = ~last_a;
        chk({tag, "_trig_cycle"}, cyc, n_trig * (lat + 2));
        chk({tag, "_trig_data"}, dout_s, exp_d);
        chk({tag, "_trig_busy"}, busy_s, 1);
        held = dout_s;
        trig_prev = 1'b1;
      end
      if (done_s) begin
        done_cyc = cyc;
        chk({tag, "_done_busy"}, busy_s, 0);
        if (n_en > 0) chk({tag, "_addr_hold"}, addr_s, last_a);
        break;
      end
    end
    start1 = 1'b0;
    start3 = 1'b0;
    if (done_cyc == 0) chk({tag, "_done_timeout"}, 0, 1);
  endtask

  typedef struct {
    bit              lat3;
    logic [7:0]      seed;
    logic [7:0]      nr;
    bit              hold;
    int unsigned     exp_n;
    logic [0:4][7:0] seq;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned nt, dc, lat, cnt_t, cnt_d;
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0;
    seed = '0; num = '0; key = 8'h5A;
    repeat (3) @(negedge clk);
    chk("rst_en",    en1,   0);
    chk("rst_addr",  addr1, 0);
    chk("rst_dout",  dout1, 0);
    chk("rst_trig",  trig1, 0);
    chk("rst_busy",  busy1, 0);
    chk("rst_done",  done1, 0);
    chk("rst_dout3", dout3, 0);
    rst = 1'b0;

    vecs[0] = '{1'b0, 8'h01, 8'd5, 1'b0, 5, {8'h01, 8'h02, 8'h04, 8'h08, 8'h11}};
    vecs[1] = '{1'b0, 8'h00, 8'd2, 1'b1, 2, {8'h01, 8'h02, 8'h00, 8'h00, 8'h00}};
    vecs[2] = '{1'b0, 8'h80, 8'd3, 1'b0, 3, {8'h80, 8'h01, 8'h02, 8'h00, 8'h00}};
    vecs[3] = '{1'b0, 8'hFF, 8'd2, 1'b0, 2, {8'hFF, 8'hFE, 8'h00, 8'h00, 8'h00}};
    vecs[4] = '{1'b0, 8'h55, 8'd0, 1'b0, 0, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[5] = '{1'b0, 8'h08, 8'd1, 1'b0, 1, {8'h08, 8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[6] = '{1'b1, 8'h3C, 8'd3, 1'b0, 3, {8'h3C, 8'h79, 8'hF3, 8'h00, 8'h00}};
    vecs[7] = '{1'b1, 8'h01, 8'd5, 1'b1, 5, {8'h01, 8'h02, 8'h04, 8'h08, 8'h11}};

    for (int i = 0; i < 8; i++) begin
      lat = vecs[i].lat3 ? 3 : 1;
      run_sweep(vecs[i].lat3, vecs[i].seed, vecs[i].nr, vecs[i].hold,
                $sformatf("v%0d", i), nt, dc);
      chk($sformatf("v%0d_trig_count", i), nt, vecs[i].exp_n);
      chk($sformatf("v%0d_done_cycle", i), dc, vecs[i].exp_n * (lat + 2) + 1);
      chk($sformatf("v%0d_read_count", i), addr_q.size(), vecs[i].exp_n);
      for (int j = 0; j < int'(vecs[i].exp_n); j++) begin
        if (j < addr_q.size())
          chk($sformatf("v%0d_addr%0d", i, j), addr_q[j], vecs[i].seq[j]);
      end
`ifdef LFSR_MATCH_EN
      chk($sformatf("v%0d_nomatch", i), vecs[i].lat3 ? match3 : match1, 0);
`endif
      @(negedge clk);
    end

    // Reset during the WAIT of the second read
    @(negedge clk);
    seed = 8'h01; num = 8'd5; start1 = 1'b1;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start1 = 1'b0;
      if (cyc == 3) chk("rst_mid_first_trig", trig1, 1);
      if (cyc == 5) begin
        chk("rst_mid_in_wait", {busy1, en1}, 2'b10);
        rst = 1'b1;
      end
    end
    @(negedge clk);
    chk("rst_mid_en",   en1,   0);
    chk("rst_mid_addr", addr1, 0);
    chk("rst_mid_dout", dout1, 0);
    chk("rst_mid_trig", trig1, 0);
    chk("rst_mid_busy", busy1, 0);
    chk("rst_mid_done", done1, 0);
    rst = 1'b0;
    cnt_t = 0;
    cnt_d = 0;
    repeat (12) begin
      @(negedge clk);
      if (trig1) cnt_t++;
      if (done1) cnt_d++;
    end
    chk("rst_mid_no_trig", cnt_t, 0);
    chk("rst_mid_no_done", cnt_d, 0);

    // Reset dominates Start
    @(negedge clk);
    rst = 1'b1; start1 = 1'b1; seed = 8'h01; num = 8'd3;
    @(negedge clk);
    chk("rst_vs_start_busy", busy1, 0);
    chk("rst_vs_start_en",   en1,   0);
    rst = 1'b0; start1 = 1'b0;
    @(negedge clk);
    chk("rst_vs_start_idle", busy1, 0);

`ifdef LFSR_MATCH_EN
    // Key equals data at address 08 (the 4th read): stop after that TRIG
    key = 8'hF7;
    run_sweep(1'b0, 8'h01, 8'd10, 1'b0, "match", nt, dc);
    chk("match_trig_count", nt, 4);
    chk("match_done_cycle", dc, 13);
    chk("match_flag",       match1, 1);
    chk("match_addr",       maddr1, 8'h08);
    key = 8'h5A;
    run_sweep(1'b0, 8'h01, 8'd1, 1'b0, "match_clr", nt, dc);
    chk("match_clr_flag", match1, 0);
    chk("match_clr_addr", maddr1, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
